button_debouncer: RTL and testbench

- Upstream conditioning stage for the one-pulser: cleans a raw, asynchronous, bouncing push-button input.
- Produces a glitch-free, clock-synchronous level `longPulse` that drives the one-pulser's `longPulse` input directly.
- Adds a saturating glitch counter so the lab bench can observe rejected bounces.

---
 rtl/button_debouncer.sv | 106 ++++++++++
 tb/tb_button_debouncer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces a raw bouncing push-button into a clean synchronous level and counts
// aborted transitions in a saturating glitch counter.
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rawButton,
    output logic                longPulse,
    output logic [GLITCH_W-1:0] glitchCount
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t              state_q;
    logic                sync1_q;
    logic                sync2_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                long_q;
    logic [GLITCH_W-1:0] glitch_q;
    logic [GLITCH_W-1:0] glitch_d;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (&v) ? v : v + GLITCH_W'(1);
    endfunction

    assign glitch_d = sat_inc(glitch_q);

    // sync2_q is the only view of the button the FSM ever sees
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= LOW;
            cnt_q    <= '0;
            long_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync1_q <= rawButton;
            sync2_q <= sync1_q;
            case (state_q)
                LOW: begin
                    if (sync2_q) begin
                        state_q <= RISE_CHK;
                        cnt_q   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (sync2_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= HIGH;
                            long_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q  <= LOW;
                        cnt_q    <= '0;
                        glitch_q <= glitch_d;
                    end
                end
                HIGH: begin
                    if (!sync2_q) begin
                        state_q <= FALL_CHK;
                        cnt_q   <= '0;
                    end
                end
                FALL_CHK: begin
                    // longPulse stays high until the low level is proven stable
                    if (!sync2_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= LOW;
                            long_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q  <= HIGH;
                        cnt_q    <= '0;
                        glitch_q <= glitch_d;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                    long_q  <= 1'b0;
                end
            endcase
        end
    end

    assign longPulse   = long_q;
    assign glitchCount = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: scoreboard of per-edge expected outputs,
// one main instance (GLITCH_W=8) and one narrow-counter instance (GLITCH_W=2).
module tb_button_debouncer;

    localparam int LAT = 2 + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rawButton;
    logic       longPulse;
    logic [7:0] glitchCount;
    logic       rawSat;
    logic       lpSat;
    logic [1:0] gcSat;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       lp;
        logic [7:0] gc;
        bit         sel;
    } sb_item_t;

    sb_item_t sb[$];

    button_debouncer #(.STABLE_CYCLES(4), .CNT_W(4), .GLITCH_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rawButton  (rawButton),
        .longPulse  (longPulse),
        .glitchCount(glitchCount)
    );

    button_debouncer #(.STABLE_CYCLES(4), .CNT_W(4), .GLITCH_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .rawButton  (rawSat),
        .longPulse  (lpSat),
        .glitchCount(gcSat)
    );

    always #5 clk = ~clk;

    task automatic check_front();
        sb_item_t   it;
        logic       obs_lp;
        logic [7:0] obs_gc;
        it     = sb.pop_front();
        obs_lp = it.sel ? lpSat : longPulse;
        obs_gc = it.sel ? {6'b0, gcSat} : glitchCount;
        n_assert++;
        assert (obs_lp === it.lp) else begin
            n_fail++;
            $error("FAIL %s longPulse: observed %0b expected %0b", it.tag, obs_lp, it.lp);
        end
        n_assert++;
        assert (obs_gc === it.gc) else begin
            n_fail++;
            $error("FAIL %s glitchCount: observed %0d expected %0d", it.tag, obs_gc, it.gc);
        end
    endtask

    task automatic tick(input bit sel, input logic raw, input logic elp,
                        input logic [7:0] egc, input string tag);
        sb_item_t it;
        if (sel) rawSat = raw;
        else     rawButton = raw;
        it.tag = tag;
        it.lp  = elp;
        it.gc  = egc;
        it.sel = sel;
        sb.push_back(it);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic hold(input bit sel, input logic raw, input int n,
                        input logic lp_a, input logic lp_b, input int lp_sw,
                        input logic [7:0] gc_a, input logic [7:0] gc_b, input int gc_sw,
                        input string tag);
        for (int k = 0; k < n; k++)
            tick(sel, raw, (k < lp_sw) ? lp_b ^ lp_b ^ lp_a : lp_b,
                 (k < gc_sw) ? gc_a : gc_b, tag);
    endtask

    initial begin
        int exp_sat[5];
        int prev;
        exp_sat = '{1, 2, 3, 3, 3};
        rst       = 1'b1;
        rawButton = 1'b1;
        rawSat    = 1'b0;

        // reset held for two edges with the button already pressed
        tick(0, 1'b1, 1'b0, 8'd0, "rst_hold");
        tick(0, 1'b1, 1'b0, 8'd0, "rst_hold");
        rst = 1'b0;
        hold(0, 1'b1, 10, 1'b0, 1'b1, LAT, 8'd0, 8'd0, 0, "rst_release");
        hold(0, 1'b0, 10, 1'b1, 1'b0, LAT, 8'd0, 8'd0, 0, "first_release");

        // clean press of 200 ns, then clean release
        hold(0, 1'b1, 20, 1'b0, 1'b1, LAT, 8'd0, 8'd0, 0, "clean_press");
        hold(0, 1'b0, 10, 1'b1, 1'b0, LAT, 8'd0, 8'd0, 0, "clean_release");

        // bounce 1,0,1,0 then settle high: two aborted rise checks
        tick(0, 1'b1, 1'b0, 8'd0, "bounce");
        tick(0, 1'b0, 1'b0, 8'd0, "bounce");
        tick(0, 1'b1, 1'b0, 8'd0, "bounce");
        tick(0, 1'b0, 1'b0, 8'd1, "bounce");
        hold(0, 1'b1, 12, 1'b0, 1'b1, LAT, 8'd1, 8'd2, 1, "bounce_settle");

        // two-edge dip while high: one aborted fall check, level never drops
        hold(0, 1'b0, 2, 1'b1, 1'b1, 0, 8'd2, 8'd2, 0, "dip_low");
        hold(0, 1'b1, 8, 1'b1, 1'b1, 0, 8'd2, 8'd3, 2, "dip_recover");

        // reset during FALL_CHK while longPulse is still high
        hold(0, 1'b0, 3, 1'b1, 1'b1, 0, 8'd3, 8'd3, 0, "fall_chk");
        rst = 1'b1;
        tick(0, 1'b0, 1'b0, 8'd0, "rst_mid");
        rst = 1'b0;
        hold(0, 1'b0, 10, 1'b0, 1'b0, 0, 8'd0, 8'd0, 0, "post_rst_low");

        // narrow counter: five isolated one-edge high glitches
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            tick(1, 1'b1, 1'b0, 8'(prev), "sat");
            for (int k = 1; k < 6; k++)
                tick(1, 1'b0, 1'b0, (k >= 3) ? 8'(exp_sat[g]) : 8'(prev), "sat");
            prev = exp_sat[g];
        end

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
